// File: rtl/pipe_stage_skid_reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Pipeline-stage register placed between two processor stages (IF/ID, ID/EX,
// EX/MEM, MEM/WB). It moves a control bundle and a data bundle under a
// valid/ready handshake. A main register (M) and a skid register (S) form a
// 2-entry buffer, so the stage sustains one transfer per cycle even though
// in_ready is registered. A synchronous flush kills every held and incoming
// entry and is tallied in a saturating counter.
//
// Parameters
//   CTRL_W          width of the control bundle; zeroed on bubble and flush
//   DATA_W          width of the data bundle
//   CLEAR_ON_FLUSH  1: data registers zeroed on flush, 0: data registers hold
//   CNT_W           width of flush_cnt
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous kill of all held and incoming entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage accepts an entry this cycle (registered)
//   in_ctrl    in   upstream control bundle
//   in_data    in   upstream data bundle
//   out_valid  out  head entry presented downstream
//   out_ready  in   downstream accepts this cycle (0 = stall)
//   out_ctrl   out  control of head entry, all-zero whenever out_valid=0
//   out_data   out  data of head entry
//   flush_cnt  out  number of flush cycles seen, saturating
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
   parameter int CTRL_W         = 8,
   parameter int DATA_W         = 208,
   parameter bit CLEAR_ON_FLUSH = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  flush_cnt
);

   // Occupancy states: EMPTY (nothing held), BUSY (M valid), FULL (M and S valid)
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;

   logic [CTRL_W-1:0] main_ctrl_p1;
   logic [DATA_W-1:0] main_data_p1;
   logic [CTRL_W-1:0] skid_ctrl_p1;
   logic [DATA_W-1:0] skid_data_p1;

   logic              take;        // upstream entry accepted at this edge
   logic              load_in;     // M <= incoming entry
   logic              load_skid;   // S <= incoming entry
   logic              promote;     // M <= S

   // Saturating increment: the counter parks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   // in_ready is a register, so gate with it: an offer made while the stage
   // is FULL is ignored and the upstream keeps holding it.
   assign take = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      load_in   = 1'b0;
      load_skid = 1'b0;
      promote   = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (take) begin
                  load_in   = 1'b1;
                  state_nxt = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (out_ready && take) begin
                  load_in   = 1'b1;
               end else if (out_ready) begin
                  state_nxt = ST_EMPTY;
               end else if (take) begin
                  // Head is stalled: park the newcomer behind it.
                  load_skid = 1'b1;
                  state_nxt = ST_FULL;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  promote   = 1'b1;
                  state_nxt = ST_BUSY;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // ---- stage boundary: control registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_EMPTY;
         in_ready     <= 1'b1;
         flush_cnt    <= '0;
         main_ctrl_p1 <= '0;
         skid_ctrl_p1 <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != ST_FULL);
         if (flush) begin
            flush_cnt    <= sat_inc(flush_cnt);
            main_ctrl_p1 <= '0;
            skid_ctrl_p1 <= '0;
         end else begin
            if (load_in) begin
               main_ctrl_p1 <= in_ctrl;
            end else if (promote) begin
               main_ctrl_p1 <= skid_ctrl_p1;
            end
            if (load_skid) begin
               skid_ctrl_p1 <= in_ctrl;
            end
         end
      end
   end

   // ---- stage boundary: data registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data_p1 <= '0;
         skid_data_p1 <= '0;
      end else if (flush) begin
         if (CLEAR_ON_FLUSH) begin
            main_data_p1 <= '0;
            skid_data_p1 <= '0;
         end
      end else begin
         if (load_in) begin
            main_data_p1 <= in_data;
         end else if (promote) begin
            main_data_p1 <= skid_data_p1;
         end
         if (load_skid) begin
            skid_data_p1 <= in_data;
         end
      end
   end

   assign out_valid = (state != ST_EMPTY);
   // A bubble must never carry live control (no RF or memory write).
   assign out_ctrl  = out_valid ? main_ctrl_p1 : '0;
   assign out_data  = main_data_p1;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//
// Bench for pipe_stage_skid_reg: directed vector table for streaming, stall,
// and flush behaviour, hand sequences for asynchronous reset while FULL and
// flush-count saturation (second instance with CNT_W=2), and a random
// valid/ready run checked against an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

   localparam int CW = 8;
   localparam int DW = 208;
   localparam int NW = 16;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [NW-1:0] flush_cnt;

   logic          flush2;
   logic          in_valid2;
   logic          in_ready2;
   logic [7:0]    in_ctrl2;
   logic [7:0]    in_data2;
   logic          out_valid2;
   logic          out_ready2;
   logic [7:0]    out_ctrl2;
   logic [7:0]    out_data2;
   logic [1:0]    flush_cnt2;

   int n_tests;
   int n_fail;

   pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(NW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .flush_cnt(flush_cnt)
   );

   pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(8), .CLEAR_ON_FLUSH(1'b1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_ctrl(in_ctrl2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2), .out_data(out_data2),
      .flush_cnt(flush_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   typedef struct {
      logic          flush;
      logic          in_valid;
      logic [CW-1:0] ctrl;
      logic          out_ready;
      logic          exp_valid;
      logic          exp_ready;
      logic [CW-1:0] exp_ctrl;
      logic [NW-1:0] exp_cnt;
   } vec_t;

   vec_t vt[$];

   function automatic logic [DW-1:0] pat(input logic [CW-1:0] c);
      return {26{c}};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addv(input logic f, input logic iv, input logic [CW-1:0] c, input logic ordy,
                       input logic ev, input logic er, input logic [CW-1:0] ec, input logic [NW-1:0] cnt);
      vec_t v;
      v.flush = f; v.in_valid = iv; v.ctrl = c; v.out_ready = ordy;
      v.exp_valid = ev; v.exp_ready = er; v.exp_ctrl = ec; v.exp_cnt = cnt;
      vt.push_back(v);
   endtask

   logic [CW-1:0] q_ctrl[$];
   logic [DW-1:0] q_data[$];

   task automatic sb_step();
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      if (out_valid && out_ready) begin
         if (q_ctrl.size() == 0) begin
            check("sb_unexpected_output", 208'(out_valid), 208'(0));
         end else begin
            ec = q_ctrl.pop_front();
            ed = q_data.pop_front();
            check("sb_ctrl", 208'(out_ctrl), 208'(ec));
            check("sb_data", out_data, ed);
         end
      end
   endtask

   initial begin
      int exp_sat[6];
      logic          holding;
      logic [CW-1:0] cur_ctrl;
      logic [DW-1:0] cur_data;
      logic [223:0]  rnd;
      int            seq;

      n_tests = 0;
      n_fail  = 0;
      exp_sat = '{1, 2, 3, 3, 3, 3};

      // streaming: ctrl 1..10 back to back, 1-cycle latency
      for (int i = 1; i <= 10; i++) addv(0, 1, CW'(i), 1, 1, 1, CW'(i), 0);
      addv(0, 0, 8'h00, 1, 0, 1, 8'h00, 0);
      // stall: A,B fill, C offered while full, then drain in order
      addv(0, 1, 8'h41, 0, 1, 1, 8'h41, 0);
      addv(0, 1, 8'h42, 0, 1, 0, 8'h41, 0);
      addv(0, 1, 8'h43, 0, 1, 0, 8'h41, 0);
      addv(0, 1, 8'h43, 1, 1, 1, 8'h42, 0);
      addv(0, 1, 8'h43, 1, 1, 1, 8'h43, 0);
      addv(0, 0, 8'h00, 1, 0, 1, 8'h00, 0);
      // flush while FULL with D (0x44) offered
      addv(0, 1, 8'h51, 0, 1, 1, 8'h51, 0);
      addv(0, 1, 8'h52, 0, 1, 0, 8'h51, 0);
      addv(1, 1, 8'h44, 1, 0, 1, 8'h00, 1);
      addv(0, 0, 8'h00, 0, 0, 1, 8'h00, 1);
      addv(0, 1, 8'h61, 1, 1, 1, 8'h61, 1);
      addv(0, 0, 8'h00, 0, 1, 1, 8'h61, 1);
      addv(0, 0, 8'h00, 1, 0, 1, 8'h00, 1);
      addv(1, 0, 8'h00, 0, 0, 1, 8'h00, 2);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
      flush2 = 1'b0; in_valid2 = 1'b0; in_ctrl2 = '0; in_data2 = '0; out_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 208'(out_valid), 208'(0));
      check("rst_in_ready", 208'(in_ready), 208'(1));
      check("rst_out_ctrl", 208'(out_ctrl), 208'(0));
      check("rst_out_data", out_data, 208'(0));
      check("rst_flush_cnt", 208'(flush_cnt), 208'(0));
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         flush     = vt[i].flush;
         in_valid  = vt[i].in_valid;
         in_ctrl   = vt[i].ctrl;
         in_data   = pat(vt[i].ctrl);
         out_ready = vt[i].out_ready;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_out_valid", i), 208'(out_valid), 208'(vt[i].exp_valid));
         check($sformatf("v%0d_in_ready", i), 208'(in_ready), 208'(vt[i].exp_ready));
         check($sformatf("v%0d_out_ctrl", i), 208'(out_ctrl), 208'(vt[i].exp_ctrl));
         check($sformatf("v%0d_flush_cnt", i), 208'(flush_cnt), 208'(vt[i].exp_cnt));
         if (vt[i].exp_valid) begin
            check($sformatf("v%0d_out_data", i), out_data, pat(vt[i].exp_ctrl));
         end else if (vt[i].flush) begin
            check($sformatf("v%0d_flush_data", i), out_data, 208'(0));
         end
      end
      flush = 1'b0;

      // asynchronous reset while FULL
      in_valid = 1'b1; in_ctrl = 8'h71; in_data = pat(8'h71); out_ready = 1'b0;
      @(posedge clk); #1;
      in_ctrl = 8'h72; in_data = pat(8'h72);
      @(posedge clk); #1;
      check("pre_rst_in_ready", 208'(in_ready), 208'(0));
      check("pre_rst_out_ctrl", 208'(out_ctrl), 208'(8'h71));
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 208'(out_valid), 208'(0));
      check("arst_in_ready", 208'(in_ready), 208'(1));
      check("arst_out_ctrl", 208'(out_ctrl), 208'(0));
      check("arst_flush_cnt", 208'(flush_cnt), 208'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // flush-count saturation on the CNT_W=2 instance
      for (int k = 0; k < 6; k++) begin
         flush2 = 1'b1;
         @(posedge clk); #1;
         check($sformatf("sat_cnt_%0d", k), 208'(flush_cnt2), 208'(exp_sat[k]));
      end
      flush2 = 1'b0;
      check("sat_out_valid", 208'(out_valid2), 208'(0));
      check("sat_in_ready", 208'(in_ready2), 208'(1));
      check("sat_out_ctrl", 208'(out_ctrl2), 208'(0));
      check("sat_out_data", 208'(out_data2), 208'(0));

      // random valid/ready against an in-order scoreboard
      holding  = 1'b0;
      seq      = 0;
      cur_ctrl = '0;
      cur_data = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (!holding && ($urandom_range(0, 99) < 60)) begin
            rnd      = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            cur_ctrl = rnd[7:0];
            cur_data = {rnd[207:32], 32'(seq)};
            seq++;
            holding  = 1'b1;
         end
         in_valid  = holding;
         in_ctrl   = cur_ctrl;
         in_data   = cur_data;
         out_ready = ($urandom_range(0, 99) < 55);
         #1;
         sb_step();
         if (in_valid && in_ready) begin
            q_ctrl.push_back(cur_ctrl);
            q_data.push_back(cur_data);
            holding = 1'b0;
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int d = 0; d < 6; d++) begin
         #1;
         sb_step();
         @(posedge clk); #1;
      end
      check("sb_drained", 208'(q_ctrl.size()), 208'(0));
      check("sb_final_valid", 208'(out_valid), 208'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
